cla_mp_sched: RTL and testbench
===============================

# cla_mp_sched

Multi-precision add scheduler for the shared 8-bit carry-lookahead adder (`eb_adder`). It arbitrates round-robin between two requesters, each presenting an `8*NBYTES`-bit add. It feeds the winning operands to the adder one byte per cycle, least significant byte first, and chains the carry through a register. The finished sum is returned with the requester ID on a valid/ready response port. The adder sits outside this block and is purely combinational; this block is its only driver.

## Interface
- `NBYTES`, default 4: operand width in bytes; legal range 1–16; operand width `W = 8*NBYTES`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `VDD`, `VSS`  in  1  power pins, passed through as in the adder; no logic function.
- `req0_valid`, `req1_valid`  in  1  requester has an add pending.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  W  operands.
- `req0_cin`, `req1_cin`  in  1  carry-in.
- `add_a`, `add_b`  out  8  byte operands to the adder.
- `add_cin`  out  1  carry-in to the adder.
- `add_y`  in  8  adder sum.
- `add_cout`  in  1  adder carry-out.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_sum`  out  W  sum.
- `rsp_cout`  out  1  final carry.
- `rsp_id`  out  1  requester that owns the result (0/1).

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE, grant:**
  - One valid requester: grant it.
  - Both valid: grant the requester that is not `last_id`.
  - `reqN_ready = (state==IDLE) & grantN`, combinational. At most one ready per cycle.
- **Accept** (`valid & ready`):
  - Latch the operands into `op_a`/`op_b`, cin into `carry`, ID into `cur_id` and `last_id`.
  - Clear `cnt`, go to RUN.
- **RUN:**
  - `add_a = op_a[8*cnt +: 8]`, `add_b = op_b[8*cnt +: 8]`, `add_cin = carry`.
  - At the clock edge: `sum[8*cnt +: 8] <= add_y`, `carry <= add_cout`, `cnt <= cnt+1`.
  - When `cnt == NBYTES-1`, go to DONE.
- **DONE:**
  - `rsp_valid = 1`; `rsp_sum = sum`, `rsp_cout = carry`, `rsp_id = cur_id`, all held stable.
  - On `rsp_valid & rsp_ready`, go to IDLE.
- **Outside RUN:** `add_a`, `add_b` and `add_cin` are driven to 0.
- **Width rules:**
  - `cnt` is `$clog2(NBYTES)` bits, minimum 1.
  - Overflow appears only in `rsp_cout`; `rsp_sum` is exactly W bits and wraps modulo 2^W.
- **Requests outside IDLE:** held by the requester (valid must stay high until ready); not accepted until return to IDLE.
- **No bypass:** a DONE→IDLE transition grants in the following cycle, never the same cycle.

## Timing
- **Reset values:**
  - `state = IDLE`, `last_id = 1` (so requester 0 wins the first tie).
  - `cnt`, `carry`, `sum`, `op_a`, `op_b`, `cur_id` all 0.
  - Therefore `rsp_valid = 0`, `rsp_sum = 0`, `rsp_cout = 0`, `rsp_id = 0`, `req*_ready` = 0 unless a request is valid, and `add_*` = 0.
- **Latency:**
  - Accept at edge T.
  - RUN covers cycles T+1 … T+NBYTES.
  - `rsp_valid` is high from cycle T+NBYTES+1.
  - Minimum request-to-request throughput is NBYTES+2 cycles.
- **Backpressure:** DONE persists while `rsp_ready = 0`, with all `rsp_*` stable; no new grant.
- **Reset mid-operation:** asynchronous return to reset values in any state; the in-flight result is discarded with no `rsp_valid` pulse, and `last_id` returns to 1.
- **`NBYTES = 1`:** RUN lasts exactly one cycle.
- **Adder path:** combinational, from registers through `eb_adder` to registers within one cycle; no multicycle path.

## Test plan
- **Carry ripple, NBYTES=4:** requester 0 sends 0xFFFFFFFF + 0x00000001, cin 0 → `rsp_sum` 0x00000000, `rsp_cout` 1, `rsp_id` 0, `rsp_valid` 5 cycles after accept.
- **Carry-in:** requester 1 sends 0x12345678 + 0x0FEDCBA9, cin 1 → `rsp_sum` 0x22222222, `rsp_cout` 0, `rsp_id` 1.
- **Arbitration tie after reset:** both requests valid → requester 0 is served first. Requester 1 is accepted in the cycle after the requester-0 response handshake. A third back-to-back tie then grants requester 0 again.
- **Backpressure:** hold `rsp_ready` low for 3 cycles in DONE → `rsp_*` unchanged, both `req*_ready` stay 0. The handshake happens on the 4th cycle.
- **Reset mid-RUN:** assert `rst` at cnt=2 → `rsp_valid` never rises. After reset, the next add 0x00000001 + 0x00000001 returns 0x00000002.
- **Idle bus:** no requests for 10 cycles → `add_a`, `add_b` and `add_cin` stay 0 and `rsp_valid` stays 0.

Source files
------------

// File: rtl/cla_mp_sched.sv
// Multi-precision add scheduler: round-robin between two requesters, streams
// operands byte-serially through the external 8-bit adder and returns the sum.
module cla_mp_sched #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  VDD,
    input  logic                  VSS,
    input  logic                  req0_valid,
    input  logic                  req1_valid,
    output logic                  req0_ready,
    output logic                  req1_ready,
    input  logic [8*NBYTES-1:0]   req0_a,
    input  logic [8*NBYTES-1:0]   req0_b,
    input  logic [8*NBYTES-1:0]   req1_a,
    input  logic [8*NBYTES-1:0]   req1_b,
    input  logic                  req0_cin,
    input  logic                  req1_cin,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_y,
    input  logic                  add_cout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [8*NBYTES-1:0]   rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_id
);

    localparam int W  = 8 * NBYTES;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   op_a, op_b, sum;
    logic [CW-1:0]  cnt;
    logic           carry, cur_id, last_id;
    logic           grant0, grant1, accept, accept_id;

    // Power pins carry no logic; folded here so they are visibly consumed.
    logic unused_pwr;
    assign unused_pwr = VDD ^ VSS;

    // On a tie the requester that was not served last wins.
    assign grant0     = req0_valid & (~req1_valid | last_id);
    assign grant1     = req1_valid & (~req0_valid | ~last_id);
    assign req0_ready = (state == IDLE) & grant0;
    assign req1_ready = (state == IDLE) & grant1;
    assign accept     = req0_ready | req1_ready;
    assign accept_id  = req1_ready;

    assign rsp_valid = (state == DONE);
    assign rsp_sum   = sum;
    assign rsp_cout  = carry;
    assign rsp_id    = cur_id;

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN: begin
                add_a   = op_a[8*cnt +: 8];
                add_b   = op_b[8*cnt +: 8];
                add_cin = carry;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    // NOTE: the operand and sum registers are reset too, because the response
    // port must read as zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last_id <= 1'b1;
            cur_id  <= 1'b0;
            cnt     <= '0;
            carry   <= 1'b0;
            sum     <= '0;
            op_a    <= '0;
            op_b    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (accept) begin
                    op_a    <= accept_id ? req1_a : req0_a;
                    op_b    <= accept_id ? req1_b : req0_b;
                    carry   <= accept_id ? req1_cin : req0_cin;
                    cur_id  <= accept_id;
                    last_id <= accept_id;
                    cnt     <= '0;
                end
                RUN: begin
                    sum[8*cnt +: 8] <= add_y;
                    carry           <= add_cout;
                    cnt             <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_mp_sched.sv
// Self-checking bench for cla_mp_sched: models the external adder and checks
// arbitration, byte streaming, latency, backpressure and reset behaviour.
module tb_cla_mp_sched;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic          req0_cin, req1_cin;
    logic [7:0]    add_a, add_b, add_y;
    logic          add_cin, add_cout;
    logic          rsp_valid, rsp_ready, rsp_cout, rsp_id;
    logic [W-1:0]  rsp_sum;
    logic [8:0]    add_res;

    int total = 0;
    int bad   = 0;

    // Requester model: pending flags and operands, plus round-robin memory.
    logic [W-1:0]  pa [2];
    logic [W-1:0]  pb [2];
    logic          pc [2];
    bit            pend [2];
    bit            last_id;

    always #5 clk = ~clk;

    // External combinational 8-bit adder.
    assign add_res  = 9'(add_a) + 9'(add_b) + 9'(add_cin);
    assign add_y    = add_res[7:0];
    assign add_cout = add_res[8];

    cla_mp_sched #(.NBYTES(NBYTES)) dut (
        .clk(clk), .rst(rst), .VDD(1'b1), .VSS(1'b0),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_cin(req0_cin), .req1_cin(req1_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_y(add_y), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id)
    );

    task automatic check(input string tag, input logic [W:0] act, input logic [W:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        req0_valid = pend[0]; req0_a = pa[0]; req0_b = pb[0]; req0_cin = pc[0];
        req1_valid = pend[1]; req1_a = pa[1]; req1_b = pb[1]; req1_cin = pc[1];
    endtask

    task automatic post(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        pend[id] = 1'b1;
        pa[id]   = a;
        pb[id]   = b;
        pc[id]   = cin;
        drive_reqs();
    endtask

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] v;
        for (int i = 0; i < NBYTES; i++) v[8*i +: 8] = 8'($urandom);
        if ($urandom_range(0, 3) == 0) v = '1;
        return v;
    endfunction

    // Serve one transaction from the IDLE state: grant, stream, response, handshake.
    task automatic serve(input int bp);
        int           win;
        logic [W:0]   full, mask, part;
        win  = (pend[0] && pend[1]) ? (last_id ? 0 : 1) : (pend[0] ? 0 : 1);
        full = {1'b0, pa[win]} + {1'b0, pb[win]} + (W+1)'(pc[win]);
        #1;
        check("ready0_grant", req0_ready, win == 0);
        check("ready1_grant", req1_ready, win == 1);
        step();
        pend[win] = 1'b0;
        last_id   = win[0];
        drive_reqs();
        for (int i = 0; i < NBYTES; i++) begin
            #1;
            mask = ((W+1)'(1) << (8 * i)) - 1'b1;
            part = ({1'b0, pa[win]} & mask) + ({1'b0, pb[win]} & mask) + (W+1)'(pc[win]);
            check("run_rsp_valid", rsp_valid, 1'b0);
            check("run_add_a", add_a, pa[win][8*i +: 8]);
            check("run_add_b", add_b, pb[win][8*i +: 8]);
            check("run_add_cin", add_cin, part[8*i]);
            check("run_readies", {req0_ready, req1_ready}, 2'b00);
            step();
        end
        for (int k = 0; k <= bp; k++) begin
            #1;
            check("done_valid", rsp_valid, 1'b1);
            check("done_sum", rsp_sum, full[W-1:0]);
            check("done_cout", rsp_cout, full[W]);
            check("done_id", rsp_id, win[0]);
            check("done_readies", {req0_ready, req1_ready}, 2'b00);
            check("done_add_idle", {add_a, add_b, add_cin}, 17'd0);
            if (k < bp) step();
        end
        rsp_ready = 1'b1;
        #1;
        check("no_bypass", {req0_ready, req1_ready}, 2'b00);
        step();
        rsp_ready = 1'b0;
        #1;
        check("post_hs_valid", rsp_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; pc[i] = 1'b0;
        end
        last_id = 1'b1;
        drive_reqs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_sum", rsp_sum, '0);
        check("rst_cout_id", {rsp_cout, rsp_id}, 2'b00);
        check("rst_readies", {req0_ready, req1_ready}, 2'b00);
        rst = 1'b0;
        #1;
        check("rst_add", {add_a, add_b, add_cin}, 17'd0);

        // Idle bus
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_add", {add_a, add_b, add_cin}, 17'd0);
            check("idle_valid", rsp_valid, 1'b0);
        end

        // Carry ripple with 3 cycles of backpressure, then carry-in
        post(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        serve(3);
        post(1, 32'h1234_5678, 32'h0FED_CBA9, 1'b1);
        serve(0);

        // Reset in the middle of RUN (cnt == 2)
        post(0, rand_op(), rand_op(), 1'b1);
        #1;
        check("rstrun_grant", req0_ready, 1'b1);
        step();
        step();
        step();
        rst = 1'b1;
        pend[0] = 1'b0;
        drive_reqs();
        last_id = 1'b1;
        #1;
        check("rstrun_valid", rsp_valid, 1'b0);
        check("rstrun_sum", rsp_sum, '0);
        check("rstrun_add", {add_a, add_b, add_cin}, 17'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < NBYTES + 2; i++) begin
            step();
            check("rstrun_no_rsp", rsp_valid, 1'b0);
        end
        post(1, 32'h0000_0001, 32'h0000_0001, 1'b0);
        serve(0);

        // Ties: requester 0 first, then 1 the cycle after the handshake, then 0 again
        post(0, rand_op(), rand_op(), 1'b0);
        post(1, rand_op(), rand_op(), 1'b1);
        serve(0);
        serve(0);
        post(0, rand_op(), rand_op(), 1'b1);
        post(1, rand_op(), rand_op(), 1'b0);
        serve(1);
        serve(0);

        // Randomized traffic
        for (int r = 0; r < 40; r++) begin
            for (int id = 0; id < 2; id++)
                if (!pend[id] && $urandom_range(0, 1) == 1)
                    post(id, rand_op(), rand_op(), 1'($urandom));
            if (!pend[0] && !pend[1])
                post(int'($urandom_range(0, 1)), rand_op(), rand_op(), 1'($urandom));
            serve(int'($urandom_range(0, 3)));
        end
        while (pend[0] || pend[1]) serve(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
